aes_key_sched_seq: RTL
======================

Name: aes_key_sched_seq

Overview:
- Iterative AES key-expansion engine: takes a 128/192/256-bit cipher key and produces the full FIPS-197 round-key word array, one 32-bit word per clock.
- Sits directly upstream of the Cipher/Decipher round stages and replaces the combinational expansion that currently feeds them.
- Uses a start/busy/done handshake; after done, the word array stays stable for the round stages until the next accepted start.

Parameters:
- MAX_WORDS, 60, capacity of the word array: 4*(14+1) words.
- OUT_W, 1920, width of w_out: 32*MAX_WORDS.

Ports:
- clk  in  1  rising-edge clock, shared with the cipher stages.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request expansion; sampled on the rising edge of clk.
- key_size  in  2  key-size select: 00=128, 01=192, 10=256, 11=invalid.
- key_in  in  256  key, MSB-aligned. 128-bit key in [255:128]; 192-bit key in [255:64]; unused LSBs are ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse: w_out is complete.
- err  out  1  one-cycle pulse: start was given with key_size=11.
- nr_out  out  4  round count of the last accepted key: 10, 12 or 14.
- w_out  out  1920  word k at bits [1919-32k -: 32].
  - 128-bit consumers take w_out[1919 -: 1408].
  - 192-bit consumers take w_out[1919 -: 1664].
  - 256-bit consumers take the full 1920 bits.

Behaviour:
- Reset: when rst_n=0 at a clock edge:
  - state=IDLE, busy=0, done=0, err=0, nr_out=0, w_out=0.
  - All counters are cleared and rcon is set to 8'h01.
  - This applies in any state, including mid-expansion; no partial result is kept.
- Key-size decode: Nk=4/6/8 and Nr=10/12/14. Total words T=4*(Nr+1)=44/52/60.
- States: IDLE, EXPAND.
- IDLE with start=1 and key_size!=11, at edge E0:
  - Latch Nk and Nr; nr_out=Nr.
  - Load w[0..Nk-1] from key_in; clear w[Nk..59].
  - Set index i=Nk, phase counter j=0, rcon=8'h01.
  - Go to EXPAND; busy=1 from E0.
- IDLE with start=1 and key_size=11:
  - err=1 for exactly one cycle.
  - No other state change; w_out and nr_out are held.
- EXPAND, on each edge, write w[i] and increment i:
  - temp=w[i-1].
  - If j==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon=xtime(rcon).
  - Else if Nk==8 and j==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp.
  - j wraps modulo Nk. No divide/modulo hardware.
  - xtime: shift left 1; XOR with 8'h1b if bit 7 was set.
- Last word: the edge that writes w[T-1] is edge E0+N, with N=T-Nk=40/46/52.
  - At that edge: state=IDLE, busy=0, done=1.
  - done deasserts on the following edge.
- Latency: start edge to done high is 40/46/52 cycles.
- Input stability: start, key_size and key_in are ignored while busy=1. No queueing.
- A start arriving in the same cycle that done=1 is accepted: the state is already IDLE.
- w_out is registered and changes only on a load edge, an EXPAND edge, or reset.
- Consumers must sample w_out only while busy=0.
- Words at index ≥ T read 0.

Decomposition:
- Shared package aes_pkg:
  - key-size encodings KS_128/KS_192/KS_256/KS_BAD;
  - NK_* and NR_* constants, MAX_WORDS, RCON_INIT;
  - xtime function.
- The same package is reused by Cipher/Decipher.
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup, instantiated 4 times for SubWord.

Test Plan:
- 128-bit key 000102030405060708090a0b0c0d0e0f, start 1 cycle:
  - done exactly 40 cycles after the start edge;
  - w[4..7]=d6aa74fd d2af72fa daa678f1 d6ab76fe;
  - w[40..43]=13111d7f e3944a17 f307a78b 4d2b30c5;
  - w[44..59]=0; nr_out=10.
- 192-bit key 000102…1617, key_size=01:
  - done at 46 cycles;
  - w[48..51]=a4970a33 1a78dc09 c418c271 e3a41d5d; nr_out=12.
- 256-bit key 000102…1e1f, key_size=10:
  - done at 52 cycles;
  - w[56..59]=24fc79cc bf0979e9 371ac23c 6d68de36; nr_out=14.
- key_size=11 with start:
  - err pulses 1 cycle; busy stays 0;
  - w_out and nr_out keep the previous 128-bit result.
- Start held high and key_in changed mid-expansion:
  - result equals the original key's schedule;
  - start asserted in the done cycle begins a new run, with busy=1 the next cycle.
- rst_n=0 for 1 cycle at cycle 20 of a 256-bit run:
  - next cycle busy=0, done=0, w_out=0;
  - a fresh 128-bit run then matches the first scenario.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: key-size encodings, round/word counts, GF(2^8) xtime.
// The Cipher/Decipher round stages import this package as well.
package aes_pkg;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;
  localparam logic [1:0] KS_BAD = 2'b11;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam int         MAX_WORDS = 60;
  localparam int         OUT_W     = 32 * MAX_WORDS;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_seq_if.sv
// Request/result bundle between the key-schedule engine and its controller.
interface aes_key_sched_seq_if;
  import aes_pkg::*;

  // start is sampled only while busy=0; done and err are single-cycle pulses,
  // and w_out/nr_out stay stable from done until the next accepted start.
  logic             start;
  logic [1:0]       key_size;
  logic [255:0]     key_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [3:0]       nr_out;
  logic [OUT_W-1:0] w_out;

  modport master (output start, key_size, key_in,
                  input  busy, done, err, nr_out, w_out);
  modport slave  (input  start, key_size, key_in,
                  output busy, done, err, nr_out, w_out);
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte per instance.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TBL[11'd2047 - {a, 3'b000} -: 8];
endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES key expansion: one 32-bit round-key word per clock into a
// 60-word register array, start/busy/done handshake, held until the next start.
module aes_key_sched_seq
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  aes_key_sched_seq_if.slave  bus,
  output logic [0:0]          dbg_state
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] w_q [MAX_WORDS];
  logic [31:0] w_d [MAX_WORDS];
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic [5:0]  last_q, last_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  nk_sel, nr_sel;
  logic [5:0]  last_sel;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w;

  always_comb begin
    nk_sel   = NK_128;
    nr_sel   = NR_128;
    last_sel = 6'd43;
    unique case (bus.key_size)
      KS_192:  begin nk_sel = NK_192; nr_sel = NR_192; last_sel = 6'd51; end
      KS_256:  begin nk_sel = NK_256; nr_sel = NR_256; last_sel = 6'd59; end
      default: begin nk_sel = NK_128; nr_sel = NR_128; last_sel = 6'd43; end
    endcase
  end

  // Word i depends on w[i-1] (optionally rotated and substituted) and w[i-Nk].
  always_comb begin
    prev_w = w_q[i_q - 6'd1];
    back_w = w_q[i_q - {2'b00, nk_q}];
    sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (j_q == 3'd0)
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    else if (nk_q == NK_256 && j_q == 3'd4)
      temp_w = sub_out;
    else
      temp_w = prev_w;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    i_d     = i_q;
    j_d     = j_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    last_d  = last_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.key_size == KS_BAD) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < MAX_WORDS; k++) w_d[k] = '0;
            for (int k = 0; k < 8; k++)
              if (k < int'(nk_sel)) w_d[k] = bus.key_in[255-32*k -: 32];
            nk_d    = nk_sel;
            nr_d    = nr_sel;
            last_d  = last_sel;
            i_d     = {2'b00, nk_sel};
            j_d     = 3'd0;
            rcon_d  = RCON_INIT;
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        w_d[i_q] = back_w ^ temp_w;
        i_d      = i_q + 6'd1;
        j_d      = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
      i_q     <= '0;
      j_q     <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      last_q  <= '0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      i_q     <= i_d;
      j_q     <= j_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      last_q  <= last_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  logic [OUT_W-1:0] w_flat;
  always_comb begin
    w_flat = '0;
    for (int k = 0; k < MAX_WORDS; k++) w_flat[OUT_W-1-32*k -: 32] = w_q[k];
  end

  assign bus.w_out  = w_flat;
  assign bus.busy   = (state_q == ST_EXPAND);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.nr_out = nr_q;
  assign dbg_state  = state_q;

endmodule
